// File: rtl/tick_scheduler.sv
// tick_scheduler: runtime-loadable multi-channel tick/level rate generator with pause and resync
module tick_scheduler #(
    parameter int CHANNELS    = 6,
    parameter int DIV_W       = 26,
    parameter int DEFAULT_DIV = 500000,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [CH_W-1:0]     load_ch,
    input  logic [DIV_W-1:0]    load_div,
    input  logic                pause,
    input  logic                resync,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] level
);
    logic [DIV_W-1:0]    div_q [CHANNELS];
    logic [DIV_W-1:0]    div_d [CHANNELS];
    logic [DIV_W-1:0]    cnt_q [CHANNELS];
    logic [DIV_W-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] level_q, level_d;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            div_d[i]   = div_q[i];
            cnt_d[i]   = cnt_q[i];
            tick_d[i]  = 1'b0;
            level_d[i] = level_q[i];
            // out-of-range load_ch never matches any channel, so it is ignored
            if (resync) begin
                cnt_d[i]   = '0;
                level_d[i] = 1'b0;
                div_d[i]   = (load && 32'(load_ch) == 32'(i)) ? load_div : div_q[i];
            end else if (load && 32'(load_ch) == 32'(i)) begin
                div_d[i] = load_div;
                cnt_d[i] = '0;
            end else if (!pause && div_q[i] != '0) begin
                tick_d[i]  = cnt_q[i] == div_q[i] - DIV_W'(1);
                cnt_d[i]   = tick_d[i] ? '0 : cnt_q[i] + DIV_W'(1);
                level_d[i] = level_q[i] ^ tick_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                div_q[i] <= DIV_W'(DEFAULT_DIV);
                cnt_q[i] <= '0;
            end
            tick_q  <= '0;
            level_q <= '0;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            level_q <= level_d;
        end
    end

    assign tick  = tick_q;
    assign level = level_q;
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: scoreboard bench for tick_scheduler with 3 channels and default divisor 4
module tb_tick_scheduler;
    logic       clk = 1'b0;
    logic       rst, load, pause, resync;
    logic [1:0] load_ch;
    logic [7:0] load_div;
    logic [2:0] tick, level;

    int errors = 0;
    int checks = 0;

    logic [2:0] m_tick, m_level;
    int         m_div [3];
    int         m_cnt [3];
    logic [5:0] exp_q [$];
    logic [5:0] e;
    logic [2:0] lv;

    tick_scheduler #(.CHANNELS(3), .DIV_W(8), .DEFAULT_DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .load_ch(load_ch), .load_div(load_div),
        .pause(pause), .resync(resync), .tick(tick), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_div[i] = 4;
                m_cnt[i] = 0;
            end
            m_tick  = '0;
            m_level = '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_tick[i] = 1'b0;
                if (resync) begin
                    m_cnt[i]   = 0;
                    m_level[i] = 1'b0;
                    if (load && int'(load_ch) == i) m_div[i] = int'(load_div);
                end else if (load && int'(load_ch) == i) begin
                    m_div[i] = int'(load_div);
                    m_cnt[i] = 0;
                end else if (!pause && m_div[i] != 0) begin
                    if (m_cnt[i] == m_div[i] - 1) begin
                        m_cnt[i]   = 0;
                        m_tick[i]  = 1'b1;
                        m_level[i] = ~m_level[i];
                    end else begin
                        m_cnt[i]++;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic ld, input logic [1:0] ch,
                        input logic [7:0] dv, input logic p, input logic rs);
        rst = r; load = ld; load_ch = ch; load_div = dv; pause = p; resync = rs;
        model_edge();
        exp_q.push_back({m_tick, m_level});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("sb_tick", 32'(tick), 32'(e[5:3]));
            check("sb_level", 32'(level), 32'(e[2:0]));
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        check("rst_out", 32'({tick, level}), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            idle();
            check("p1_tick", 32'(tick), (k % 4 == 0) ? 32'd7 : 32'd0);
            check("p1_level", 32'(level), ((k / 4) % 2 == 1) ? 32'd7 : 32'd0);
        end
        step(1'b1, 1'b1, 2'd1, 8'd1, 1'b0, 1'b0);
        for (int k = 11; k <= 16; k++) begin
            idle();
            check("d1_tick1", 32'(tick[1]), 32'd1);
            check("d1_others", 32'({tick[2], tick[0]}), (k % 4 == 0) ? 32'd3 : 32'd0);
        end
        idle();
        idle();
        lv = level;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
            check("pz_tick", 32'(tick), 32'd0);
            check("pz_level", 32'(level), 32'(lv));
        end
        idle();
        check("pz_resume1", 32'(tick[0]), 32'd0);
        idle();
        check("pz_resume2", 32'(tick[0]), 32'd1);
        step(1'b1, 1'b1, 2'd2, 8'd0, 1'b0, 1'b0);
        lv = level;
        for (int k = 0; k < 6; k++) begin
            idle();
            check("d0_tick", 32'(tick[2]), 32'd0);
            check("d0_level", 32'(level[2]), 32'(lv[2]));
        end
        step(1'b1, 1'b1, 2'd2, 8'd3, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            idle();
            check("d3_tick", 32'(tick[2]), 32'(k == 3));
        end
        step(1'b1, 1'b1, 2'd0, 8'd5, 1'b0, 1'b0);
        idle();
        idle();
        idle();
        step(1'b1, 1'b1, 2'd2, 8'd7, 1'b0, 1'b0);
        idle();
        idle();
        step(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        check("rs_out", 32'({tick, level}), 32'd0);
        for (int k = 1; k <= 35; k++) begin
            idle();
            check("rs_t0", 32'(tick[0]), 32'(k % 5 == 0));
            check("rs_t2", 32'(tick[2]), 32'(k % 7 == 0));
        end
        step(1'b1, 1'b1, 2'd3, 8'd2, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) idle();
        step(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        idle();
        step(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        check("mrst_out", 32'({tick, level}), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            idle();
            check("mrst_tick", 32'(tick), (k % 4 == 0) ? 32'd7 : 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
